// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the block-RAM port arbiter: default geometry and FSM state encodings.
package mem_port_arbiter_pkg;

  localparam int NUM_REQ_DEF    = 2;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  // Index width that stays at least one bit wide for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshake, response and RAM-port bundle for mem_port_arbiter.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  localparam int GW = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_wen;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          mem_wen;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_wdata;
  logic [DATA_WIDTH-1:0]         mem_rdata;
  logic                          busy;
  logic [GW-1:0]                 grant_id;

  modport slave (
    input  req_valid, req_wen, req_lock, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_wen, mem_addr, mem_wdata, busy, grant_id
  );

  modport master (
    output req_valid, req_wen, req_lock, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_wen, mem_addr, mem_wdata, busy, grant_id
  );

endinterface

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of valid at or after ptr, wrapping.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [N-1:0] rot_s;
  logic [IW:0]  sum_s;
  logic         hit_s;

  // Rotate so ptr sits at bit 0, take the first hit, then map the offset back.
  always_comb begin
    rot_s = N'({valid, valid} >> ptr);
    found = 1'b0;
    sum_s = '0;
    hit_s = 1'b0;
    for (int j = 0; j < N; j++) begin
      hit_s = rot_s[0] & ~found;
      sum_s = hit_s ? ({1'b0, ptr} + (IW+1)'(j)) : sum_s;
      found = found | hit_s;
      rot_s = rot_s >> 1;
    end
    if (sum_s >= (IW+1)'(N)) begin
      sum_s = sum_s - (IW+1)'(N);
    end else begin
      sum_s = sum_s;
    end
    idx   = sum_s[IW-1:0];
    grant = found ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter with optional grant lock, sharing one synchronous-read RAM port.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam int GW = idx_width(NUM_REQ);

  arb_state_e             state_q, state_d;
  logic                   mem_wen_q, mem_wen_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic [GW-1:0]          rr_ptr_q, rr_ptr_d;
  logic                   lock_v_q, lock_v_d;
  logic [GW-1:0]          lock_id_q, lock_id_d;

  logic [NUM_REQ-1:0]     ready_s;
  logic [GW-1:0]          win_s;
  logic [NUM_REQ-1:0]     rr_grant_s;
  logic [GW-1:0]          rr_idx_s;
  logic                   rr_found_s;
  logic [ADDR_WIDTH-1:0]  addr_a [NUM_REQ];
  logic [DATA_WIDTH-1:0]  wdata_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[g] = bus.req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_picker #(.N(NUM_REQ), .IW(GW)) u_picker (
    .valid (bus.req_valid),
    .ptr   (rr_ptr_q),
    .grant (rr_grant_s),
    .idx   (rr_idx_s),
    .found (rr_found_s)
  );

  // Next-state, capture and lock bookkeeping for the IDLE -> ACCESS -> RESP cycle.
  always_comb begin
    state_d     = state_q;
    mem_wen_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = '0;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    lock_v_d    = lock_v_q;
    lock_id_d   = lock_id_q;
    ready_s     = '0;
    win_s       = rr_idx_s;
    case (state_q)
      ST_IDLE: begin
        if (reset) begin
          ready_s = '0;
        end else if (lock_v_q) begin
          // An idle owner gives up the lock; round-robin resumes on the following cycle.
          win_s = lock_id_q;
          if (bus.req_valid[lock_id_q]) begin
            ready_s = NUM_REQ'(1) << lock_id_q;
          end else begin
            lock_v_d = 1'b0;
          end
        end else begin
          ready_s = rr_found_s ? rr_grant_s : '0;
        end
        if (ready_s != '0) begin
          mem_wen_d   = bus.req_wen[win_s];
          mem_addr_d  = addr_a[win_s];
          mem_wdata_d = wdata_a[win_s];
          grant_d     = win_s;
          rr_ptr_d    = (win_s == GW'(NUM_REQ - 1)) ? '0 : win_s + GW'(1);
          lock_v_d    = bus.req_lock[win_s];
          lock_id_d   = win_s;
          state_d     = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        rsp_valid_d = NUM_REQ'(1) << grant_q;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= '0;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      lock_v_q    <= 1'b0;
      lock_id_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_v_q    <= lock_v_d;
      lock_id_q   <= lock_id_d;
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = bus.mem_rdata;
  assign bus.mem_wen   = mem_wen_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.grant_id  = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a cycle-age reference model.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mem_port_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(8), .DATA_WIDTH(16)) bus_if ();

  mem_port_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ram_init(input int a);
    return 16'((a * 16'h0101) ^ 16'h5A5A);
  endfunction

  // RAM with one-cycle synchronous read, returning the pre-write contents.
  logic [15:0] ram [256];
  initial begin
    logic [15:0] rd;
    for (int a = 0; a < 256; a++) ram[a] = ram_init(a);
    ram[8'h10] = 16'hBEEF;
    forever begin
      @(posedge clk);
      rd = ram[bus_if.mem_addr];
      if (bus_if.mem_wen) ram[bus_if.mem_addr] = bus_if.mem_wdata;
      bus_if.mem_rdata <= rd;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic l,
                         input logic [7:0] a, input logic [15:0] d);
    logic [1:0]  m;
    logic [15:0] am;
    logic [31:0] dm;
    m  = 2'b01 << i;
    am = 16'h00FF << (i * 8);
    dm = 32'h0000FFFF << (i * 16);
    bus_if.req_valid = (bus_if.req_valid & ~m) | (v ? m : 2'b00);
    bus_if.req_wen   = (bus_if.req_wen & ~m) | (w ? m : 2'b00);
    bus_if.req_lock  = (bus_if.req_lock & ~m) | (l ? m : 2'b00);
    bus_if.req_addr  = (bus_if.req_addr & ~am) | (16'(a) << (i * 8));
    bus_if.req_wdata = (bus_if.req_wdata & ~dm) | (32'(d) << (i * 16));
  endtask

  task automatic clear_reqs();
    bus_if.req_valid = 2'b00;
    bus_if.req_wen   = 2'b00;
    bus_if.req_lock  = 2'b00;
    bus_if.req_addr  = 16'h0000;
    bus_if.req_wdata = 32'h0000_0000;
  endtask

  // Reference model: tracks cycles since the last accept instead of an FSM state.
  int          m_age, m_ptr, m_grant, m_lock_id, m_win;
  bit          m_lock_v, m_wen;
  logic [7:0]  m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_ram [256];
  logic [1:0]  m_ready;

  initial begin
    for (int a = 0; a < 256; a++) m_ram[a] = ram_init(a);
    m_ram[8'h10] = 16'hBEEF;
    m_age = 99; m_ptr = 0; m_grant = 0; m_lock_id = 0; m_lock_v = 1'b0;
    m_wen = 1'b0; m_addr = 8'h00; m_wdata = 16'h0000;
    forever begin
      @(negedge clk);
      m_ready = 2'b00;
      m_win   = -1;
      if (!reset && m_age >= 3) begin
        if (m_lock_v) begin
          if (((bus_if.req_valid >> m_lock_id) & 2'b01) != 2'b00) m_win = m_lock_id;
        end else begin
          for (int k = 0; k < 2; k++)
            if (m_win < 0 && ((bus_if.req_valid >> ((m_ptr + k) % 2)) & 2'b01) != 2'b00)
              m_win = (m_ptr + k) % 2;
        end
        if (m_win >= 0) m_ready = 2'b01 << m_win;
      end
      chk("req_ready", bus_if.req_ready, m_ready);
      chk("busy", bus_if.busy, (m_age == 1 || m_age == 2));
      chk("mem_wen", bus_if.mem_wen, (m_age == 1 && m_wen));
      chk("rsp_valid", bus_if.rsp_valid, (m_age == 2) ? (2'b01 << m_grant) : 2'b00);
      chk("grant_id", bus_if.grant_id, m_grant);
      chk("mem_addr", bus_if.mem_addr, m_addr);
      chk("mem_wdata", bus_if.mem_wdata, m_wdata);
      if (m_age == 2 && !m_wen) chk("rsp_rdata", bus_if.rsp_rdata, m_ram[m_addr]);

      if (m_age == 1 && m_wen) m_ram[m_addr] = m_wdata;
      if (reset) begin
        m_age = 99; m_ptr = 0; m_grant = 0; m_lock_v = 1'b0; m_lock_id = 0;
        m_wen = 1'b0; m_addr = 8'h00; m_wdata = 16'h0000;
      end else if (m_win >= 0) begin
        m_age     = 1;
        m_grant   = m_win;
        m_ptr     = (m_win + 1) % 2;
        m_lock_v  = ((bus_if.req_lock >> m_win) & 2'b01) != 2'b00;
        m_lock_id = m_win;
        m_wen     = ((bus_if.req_wen >> m_win) & 2'b01) != 2'b00;
        m_addr    = 8'(bus_if.req_addr >> (m_win * 8));
        m_wdata   = 16'(bus_if.req_wdata >> (m_win * 16));
      end else begin
        if (m_age >= 3 && m_lock_v) m_lock_v = 1'b0;
        if (m_age < 99) m_age++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    clear_reqs();
    repeat (3) tick();
    reset = 1'b0;

    // Read of a preloaded word.
    set_req(0, 1'b1, 1'b0, 1'b0, 8'h10, 16'h0000);
    @(negedge clk); chk("t1_ready", bus_if.req_ready, 2'b01);
    tick(); clear_reqs();
    @(negedge clk); chk("t1_addr", bus_if.mem_addr, 8'h10); chk("t1_busy", bus_if.busy, 1'b1);
    tick();
    @(negedge clk); chk("t1_rsp", bus_if.rsp_valid, 2'b01); chk("t1_rdata", bus_if.rsp_rdata, 16'hBEEF);
    tick();

    // Write then readback.
    set_req(1, 1'b1, 1'b1, 1'b0, 8'h22, 16'h1234);
    @(negedge clk); chk("t2_ready", bus_if.req_ready, 2'b10); chk("t2_wen_early", bus_if.mem_wen, 1'b0);
    tick(); clear_reqs();
    @(negedge clk); chk("t2_wen", bus_if.mem_wen, 1'b1); chk("t2_wdata", bus_if.mem_wdata, 16'h1234);
    tick();
    @(negedge clk); chk("t2_rsp", bus_if.rsp_valid, 2'b10); chk("t2_wen_late", bus_if.mem_wen, 1'b0);
    tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 8'h22, 16'h0000);
    @(negedge clk); chk("t2_rd_ready", bus_if.req_ready, 2'b01);
    tick(); clear_reqs(); tick();
    @(negedge clk); chk("t2_rdback", bus_if.rsp_rdata, 16'h1234);
    tick();

    // Contention from reset: alternating grants every third cycle.
    reset = 1'b1;
    set_req(0, 1'b1, 1'b0, 1'b0, 8'h01, 16'h0000);
    set_req(1, 1'b1, 1'b0, 1'b0, 8'h02, 16'h0000);
    tick(); reset = 1'b0;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk); chk("t3_grant", bus_if.req_ready, (g % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      for (int s = 0; s < 2; s++) begin
        @(negedge clk); chk("t3_gap", bus_if.req_ready, 2'b00);
        tick();
      end
    end

    // Lock: three locked plus one unlocked req1 access while req0 waits.
    reset = 1'b1; clear_reqs(); tick(); reset = 1'b0;
    set_req(1, 1'b1, 1'b0, 1'b1, 8'h30, 16'h0000);
    @(negedge clk); chk("t4_first", bus_if.req_ready, 2'b10);
    tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 8'h31, 16'h0000);
    n = 1;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(negedge clk);
      if (bus_if.req_ready != 2'b00) begin
        chk("t4_grant", bus_if.req_ready, (n < 4) ? 2'b10 : 2'b01);
        n++;
      end
      tick();
      if (n == 3) set_req(1, 1'b1, 1'b0, 1'b0, 8'h32, 16'h0000);
    end
    chk("t4_count", n, 5);
    clear_reqs(); tick(); tick();

    // Lock release when the owner goes idle.
    reset = 1'b1; tick(); reset = 1'b0;
    set_req(0, 1'b1, 1'b0, 1'b1, 8'h40, 16'h0000);
    @(negedge clk); chk("t5_ready", bus_if.req_ready, 2'b01);
    tick();
    set_req(0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    set_req(1, 1'b1, 1'b0, 1'b0, 8'h41, 16'h0000);
    tick(); tick();
    @(negedge clk); chk("t5_hold", bus_if.req_ready, 2'b00);
    tick();
    @(negedge clk); chk("t5_rr", bus_if.req_ready, 2'b10);
    tick(); clear_reqs(); tick(); tick();

    // Reset in the accept cycle of a write.
    set_req(0, 1'b1, 1'b0, 1'b0, 8'h05, 16'h0000);
    tick(); clear_reqs(); tick(); tick();
    set_req(0, 1'b1, 1'b1, 1'b0, 8'h50, 16'hDEAD);
    reset = 1'b1;
    @(negedge clk); chk("t6_ready", bus_if.req_ready, 2'b00);
    tick(); reset = 1'b0; clear_reqs();
    @(negedge clk); chk("t6_wen", bus_if.mem_wen, 1'b0); chk("t6_busy", bus_if.busy, 1'b0);
    tick();
    @(negedge clk); chk("t6_rsp", bus_if.rsp_valid, 2'b00);
    tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 8'h50, 16'h0000);
    set_req(1, 1'b1, 1'b0, 1'b0, 8'h51, 16'h0000);
    @(negedge clk); chk("t6_ptr", bus_if.req_ready, 2'b01);
    tick(); clear_reqs(); tick(); tick();
    @(negedge clk); chk("t6_mem", bus_if.rsp_rdata, ram_init(8'h50));
    tick();

    // Random traffic, including occasional resets and locks.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < 2; i++)
        set_req(i, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0), 8'($urandom), 16'($urandom));
      tick();
    end
    reset = 1'b0;
    clear_reqs();
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
